multicycle_shifter: RTL and testbench
=====================================

# multicycle_shifter

Parametrised, iterative shifter supporting logical-left, logical-right, arithmetic-right and rotate-right, processing up to STEP bit positions per clock. It generalises the fixed 1-bit, 64-bit arithmetic-right shift stage used in the processor datapath to any power-of-two width and any shift amount, and it carries its own start/done handshake. The processor's ALU shift path uses it where a full single-cycle barrel shifter costs too much area.

## Interface
- WIDTH, 64, data width; power of two, >= 2
- STEP, 1, max bit positions shifted per RUN cycle; power of two, 1..WIDTH
- SHAMT_W, $clog2(WIDTH), shift-amount width (derived; do not override)
- clock  in  1  single clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  request; accepted only on a rising edge where ready=1
- op  in  2  00 SLL, 01 SRL, 10 SRA, 11 ROR; sampled at accept
- data_in  in  WIDTH  operand; sampled at accept
- shamt  in  SHAMT_W  shift amount 0..WIDTH-1; sampled at accept
- ready  out  1  high only in IDLE
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse; result valid
- result  out  WIDTH  shifted value; held stable from done until the next accept

## Operation
- States: IDLE, RUN, DONE (encoding from package).
- IDLE: ready=1. When start=1, latch op, data_in into working register acc, shamt into counter cnt; go to RUN.
- RUN: if cnt==0, go to DONE. Otherwise k = min(STEP, cnt): acc <= shift(acc, op, k), cnt <= cnt - k.
- DONE: done=1, result=acc; next edge goes to IDLE unconditionally.
- Shift rules per step of k:
  - SLL fills k zeros at the LSBs.
  - SRL fills k zeros at the MSBs.
  - SRA replicates acc[WIDTH-1] into the k MSBs.
  - ROR moves the k LSBs into the MSBs.
  - Composition of steps equals a single shift by shamt.
- shamt=0: result equals data_in for every op.
- start while busy or in DONE: ignored, with no effect on state, operands or outputs. There is no queuing.
- op, data_in and shamt may change freely after accept.
- result is driven from acc at all times. It changes only during RUN (intermediate values are not meaningful) and at accept.
- Reset (asynchronous, any state, including mid-RUN): state=IDLE, acc=0, cnt=0.
  - Outputs: ready=1, busy=0, done=0, result=0.
  - The in-flight operation is discarded; no done pulse is issued.
- Reset release: the first accept is possible on the first rising edge after reset_n goes high.

## Timing
- Accept edge E0. RUN lasts N = ceil(shamt/STEP) + 1 cycles. done is high in the cycle after edge E0+N. ready returns at edge E0+N+1.
- Total start-to-next-accept spacing: N+2 edges. Minimum (shamt=0): done 2 cycles after the start cycle.
- Worst case: shamt=WIDTH-1, STEP=1 gives N=WIDTH.
- Outputs are registered or decoded purely from state. There is no combinational path from the inputs to any output.
- cnt is SHAMT_W bits wide and never underflows, because k <= cnt by construction.

## Structure
- Package shift_pkg holds:
  - op encodings SH_SLL, SH_SRL, SH_SRA, SH_ROR
  - state encodings ST_IDLE, ST_RUN, ST_DONE
  - the OP_W=2 constant
- Sub-module shift_step (parameters WIDTH, STEP):
  - Combinational single-stage shifter with inputs in, op, k (0..STEP) and output out.
  - With STEP=1 and op=SRA it reduces to the existing 1-bit arithmetic-right stage.
- Top module: FSM, acc/cnt registers, min(STEP,cnt) selection. Target about 150-250 lines total.

## Test plan
- WIDTH=64, STEP=1, SRA, data 0x8000_0000_0000_0000, shamt=1 -> result 0xC000_0000_0000_0000; done in the cycle after edge E0+2.
- WIDTH=64, STEP=4, SRA, data 0x8000_0000_0000_0000, shamt=63 -> result 0xFFFF_FFFF_FFFF_FFFF; N=17; ready low for 18 cycles.
- WIDTH=32, STEP=4, ROR, data 0x0000_0001, shamt=4 -> 0x1000_0000; SLL, data 0x0000_00FF, shamt=0 -> 0x0000_00FF with N=1.
- WIDTH=32, STEP=8, SRL, data 0xF000_0000, shamt=13 -> 0x0007_8000; start pulsed with different operands during RUN and DONE -> ignored, result unchanged.
- Assert reset_n low mid-RUN (SLL, shamt=20, STEP=1) -> immediately ready=1, busy=0, done=0, result=0, with no later done; a fresh accept after release completes correctly.
- Randomised ops, data and shamt against a reference model (<<, >>, >>>, rotate) for STEP in {1,2,WIDTH}. Check result and the exact latency N for each.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared encodings for the iterative shifter: operation codes, FSM states
// and the operation field width.
package shift_pkg;

    localparam int OP_W = 2;

    typedef enum logic [OP_W-1:0] {
        SH_SLL = 2'b00,
        SH_SRL = 2'b01,
        SH_SRA = 2'b10,
        SH_ROR = 2'b11
    } shift_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } shift_state_e;

endpackage

// File: rtl/shift_step.sv
// Combinational single-stage shifter: moves `in` by k (0..STEP) positions.
// With STEP=1 and op=SRA it is the classic 1-bit arithmetic-right stage.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int STEP  = 1,
    parameter int KW    = $clog2(STEP + 1)
) (
    input  logic [WIDTH-1:0] in,
    input  shift_op_e        op,
    input  logic [KW-1:0]    k,
    output logic [WIDTH-1:0] out
);

    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] shr;

    // Right-going ops share one shifter: the upper half supplies the fill bits
    // (zeros, sign copies, or the operand itself for rotate).
    always_comb begin
        hi = '0;
        case (op)
            SH_SRA:  hi = {WIDTH{in[WIDTH-1]}};
            SH_ROR:  hi = in;
            default: hi = '0;
        endcase
        shr = WIDTH'({hi, in} >> k);
        out = (op == SH_SLL) ? (in << k) : shr;
    end

endmodule

// File: rtl/multicycle_shifter.sv
// Iterative shifter with start/done handshake; shifts up to STEP positions
// per RUN cycle until the requested amount is consumed.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | ready; start latches op, data_in -> acc, shamt -> cnt
//   ST_RUN  | shift acc by min(STEP, cnt) each cycle until cnt reaches 0
//   ST_DONE | one-cycle done pulse, result valid; always returns to idle
module multicycle_shifter
    import shift_pkg::*;
#(
    parameter int WIDTH   = 64,
    parameter int STEP    = 1,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    input  logic [OP_W-1:0]    op,
    input  logic [WIDTH-1:0]   data_in,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               ready,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result
);

    localparam int KW = $clog2(STEP + 1);

    shift_state_e       state_q, state_d;
    shift_op_e          op_q, op_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [KW-1:0]      k;
    logic [WIDTH-1:0]   step_out;

    // k = min(STEP, cnt); compared as integers since STEP may exceed cnt's range
    always_comb begin
        if (int'(cnt_q) >= STEP) begin
            k = KW'(STEP);
        end else begin
            k = KW'(cnt_q);
        end
    end

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP),
        .KW    (KW)
    ) u_step (
        .in  (acc_q),
        .op  (op_q),
        .k   (k),
        .out (step_out)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            op_q    <= SH_SLL;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d    = shift_op_e'(op);
                    acc_d   = data_in;
                    cnt_d   = shamt;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    // k never exceeds cnt, so the narrowing cast cannot lose bits
                    acc_d = step_out;
                    cnt_d = cnt_q - SHAMT_W'(k);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign ready  = (state_q == ST_IDLE);
    assign busy   = (state_q == ST_RUN);
    assign done   = (state_q == ST_DONE);
    assign result = acc_q;

endmodule

// File: tb/tb_multicycle_shifter.sv
// Directed and reference-model checks of multicycle_shifter over several
// WIDTH/STEP configurations sharing one operand bus.
module tb_multicycle_shifter;

    logic        clock;
    logic        reset_n;
    logic [5:0]  start_v;
    logic [1:0]  op;
    logic [63:0] data;
    logic [5:0]  shamt;

    logic [5:0]  ready_v, busy_v, done_v;
    logic [63:0] res_v [6];
    logic [31:0] r32 [2:3];

    int errors = 0;
    int checks = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // idx: 0 W64/S1, 1 W64/S4, 2 W32/S4, 3 W32/S8, 4 W64/S2, 5 W64/S64
    multicycle_shifter #(.WIDTH(64), .STEP(1)) u0 (
        .clock(clock), .reset_n(reset_n), .start(start_v[0]), .op(op),
        .data_in(data), .shamt(shamt), .ready(ready_v[0]), .busy(busy_v[0]),
        .done(done_v[0]), .result(res_v[0]));
    multicycle_shifter #(.WIDTH(64), .STEP(4)) u1 (
        .clock(clock), .reset_n(reset_n), .start(start_v[1]), .op(op),
        .data_in(data), .shamt(shamt), .ready(ready_v[1]), .busy(busy_v[1]),
        .done(done_v[1]), .result(res_v[1]));
    multicycle_shifter #(.WIDTH(32), .STEP(4)) u2 (
        .clock(clock), .reset_n(reset_n), .start(start_v[2]), .op(op),
        .data_in(data[31:0]), .shamt(shamt[4:0]), .ready(ready_v[2]), .busy(busy_v[2]),
        .done(done_v[2]), .result(r32[2]));
    multicycle_shifter #(.WIDTH(32), .STEP(8)) u3 (
        .clock(clock), .reset_n(reset_n), .start(start_v[3]), .op(op),
        .data_in(data[31:0]), .shamt(shamt[4:0]), .ready(ready_v[3]), .busy(busy_v[3]),
        .done(done_v[3]), .result(r32[3]));
    multicycle_shifter #(.WIDTH(64), .STEP(2)) u4 (
        .clock(clock), .reset_n(reset_n), .start(start_v[4]), .op(op),
        .data_in(data), .shamt(shamt), .ready(ready_v[4]), .busy(busy_v[4]),
        .done(done_v[4]), .result(res_v[4]));
    multicycle_shifter #(.WIDTH(64), .STEP(64)) u5 (
        .clock(clock), .reset_n(reset_n), .start(start_v[5]), .op(op),
        .data_in(data), .shamt(shamt), .ready(ready_v[5]), .busy(busy_v[5]),
        .done(done_v[5]), .result(res_v[5]));

    assign res_v[2] = {32'h0, r32[2]};
    assign res_v[3] = {32'h0, r32[3]};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [1:0] o, input logic [63:0] d, input int s);
        logic [63:0] r;
        case (o)
            2'd0: r = d << s;
            2'd1: r = d >> s;
            2'd2: r = $signed(d) >>> s;
            default: r = (s == 0) ? d : ((d >> s) | (d << (64 - s)));
        endcase
        return r;
    endfunction

    // poke holds start high with scrambled operands through RUN and DONE
    task automatic run(input int idx, input logic [1:0] o, input logic [63:0] d,
                       input logic [5:0] s, input logic [63:0] exp, input int expn,
                       input bit poke, input string tag);
        int n;
        @(negedge clock);
        op = o; data = d; shamt = s; start_v[idx] = 1'b1;
        @(posedge clock); #1;
        start_v[idx] = poke;
        op = ~o; data = ~d; shamt = s ^ 6'h15;
        chk({tag, "_busy"}, 64'(busy_v[idx]), 64'd1);
        n = 0;
        while (!done_v[idx] && n < 200) begin
            @(posedge clock); #1;
            n++;
        end
        chk({tag, "_lat"}, 64'(n), 64'(expn));
        chk({tag, "_res"}, res_v[idx], exp);
        chk({tag, "_rdy_lo"}, 64'(ready_v[idx]), 64'd0);
        @(posedge clock); #1;
        start_v[idx] = 1'b0;
        chk({tag, "_rdy_hi"}, 64'(ready_v[idx]), 64'd1);
        chk({tag, "_done_lo"}, 64'(done_v[idx]), 64'd0);
        chk({tag, "_hold"}, res_v[idx], exp);
    endtask

    initial begin
        int steps [3];
        int insts [3];
        int ndone;
        logic [1:0]  o;
        logic [63:0] d;
        logic [5:0]  s;

        steps = '{1, 2, 64};
        insts = '{0, 4, 5};
        reset_n = 1'b0;
        start_v = '0;
        op = '0; data = '0; shamt = '0;

        #3;
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("rst_ready%0d", i), 64'(ready_v[i]), 64'd1);
            chk($sformatf("rst_busy%0d", i), 64'(busy_v[i]), 64'd0);
            chk($sformatf("rst_done%0d", i), 64'(done_v[i]), 64'd0);
            chk($sformatf("rst_res%0d", i), res_v[i], 64'd0);
        end
        @(negedge clock);
        reset_n = 1'b1;

        run(0, 2'd2, 64'h8000_0000_0000_0000, 6'd1,  64'hC000_0000_0000_0000, 2,  1'b0, "sra64s1");
        run(1, 2'd2, 64'h8000_0000_0000_0000, 6'd63, 64'hFFFF_FFFF_FFFF_FFFF, 17, 1'b0, "sra64s4");
        run(2, 2'd3, 64'h0000_0001, 6'd4, 64'h1000_0000, 2, 1'b0, "ror32s4");
        run(2, 2'd0, 64'h0000_00FF, 6'd0, 64'h0000_00FF, 1, 1'b0, "sll32z");
        run(3, 2'd1, 64'hF000_0000, 6'd13, 64'h0007_8000, 3, 1'b1, "srl32ign");
        run(3, 2'd2, 64'h8000_0001, 6'd31, 64'hFFFF_FFFF, 5, 1'b0, "sra32max");

        // reset in the middle of a long SLL
        @(negedge clock);
        op = 2'd0; data = 64'h1234_5678_9ABC_DEF0; shamt = 6'd20; start_v[0] = 1'b1;
        @(posedge clock); #1;
        start_v[0] = 1'b0;
        repeat (5) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_ready", 64'(ready_v[0]), 64'd1);
        chk("mid_rst_busy", 64'(busy_v[0]), 64'd0);
        chk("mid_rst_done", 64'(done_v[0]), 64'd0);
        chk("mid_rst_res", res_v[0], 64'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clock); #1;
            if (done_v[0]) ndone++;
        end
        chk("mid_rst_nodone", 64'(ndone), 64'd0);
        run(0, 2'd0, 64'h1, 6'd20, 64'h0000_0000_0010_0000, 21, 1'b0, "post_rst");

        for (int t = 0; t < 3; t++) begin
            for (int r = 0; r < 8; r++) begin
                o = 2'($urandom_range(0, 3));
                d = {$urandom, $urandom};
                s = (r == 0) ? 6'd63 : 6'($urandom_range(0, 63));
                run(insts[t], o, d, s, model(o, d, int'(s)),
                    (int'(s) + steps[t] - 1) / steps[t] + 1, 1'b0,
                    $sformatf("rnd_s%0d_%0d", steps[t], r));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
